// File: rtl/fuec_48_32_pkg.sv
// Shared FUEC(48,32) constants: data columns of H, code geometry, check-bit helper
// and injector state encoding.
package fuec_48_32_pkg;

  localparam int FUEC_N = 48;
  localparam int FUEC_K = 32;
  localparam int FUEC_R = 16;

  // Row j selects the data bits that feed check bit j. Data bit i (i<16) has column
  // {i, i+1}; data bit 16+k has column {k, k+3} (indices mod 16).
  localparam logic [FUEC_R-1:0][FUEC_K-1:0] FUEC_H_DATA = {
    32'h9000_C000, 32'h4800_6000, 32'h2400_3000, 32'h1200_1800,
    32'h0900_0C00, 32'h0480_0600, 32'h0240_0300, 32'h0120_0180,
    32'h0090_00C0, 32'h0048_0060, 32'h0024_0030, 32'h0012_0018,
    32'h0009_000C, 32'h8004_0006, 32'h4002_0003, 32'h2001_8001
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STICKY = 2'd2
  } inj_state_t;

  function automatic logic [FUEC_R-1:0] fuec_check(input logic [FUEC_K-1:0] data);
    logic [FUEC_R-1:0] c;
    c = '0;
    for (int j = 0; j < FUEC_R; j++) c[j] = ^(data & FUEC_H_DATA[j]);
    return c;
  endfunction

endpackage

// File: rtl/fuec_pipe_stage.sv
// One valid/ready register slice; the slot refills whenever it is empty or being drained.
module fuec_pipe_stage #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) m_data <= s_data;
    end
  end

endmodule

// File: rtl/fuec_encoder_48_32_stream.sv
// Streaming FUEC(48,32) encoder with an output-side XOR error injector for decoder tests.
// state  | meaning
// IDLE   | no mask applied
// ARMED  | mask applied to the next transferred codeword only
// STICKY | mask applied to every codeword until inj_clr
module fuec_encoder_48_32_stream
  import fuec_48_32_pkg::*;
#(
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_code,
  input  logic             inj_load,
  input  logic [47:0]      inj_mask,
  input  logic             inj_sticky,
  input  logic             inj_clr,
  output logic             inj_active,
  output logic [CNT_W-1:0] word_cnt
);

  logic              code_v;
  logic [FUEC_N-1:0] code_q;
  logic              in_ready;

  // Any PIPE_STAGES value other than 1 builds the two-stage split-parity pipe.
  if (PIPE_STAGES == 1) begin : g_one
    fuec_pipe_stage #(.W(FUEC_N)) u_st1 (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (in_ready),
      .s_data  ({s_data, fuec_check(s_data)}),
      .m_valid (code_v),
      .m_ready (m_ready),
      .m_data  (code_q)
    );
  end else begin : g_two
    logic [FUEC_R-1:0]          part_lo;
    logic [FUEC_R-1:0]          part_hi;
    logic                       st1_v;
    logic                       st2_ready;
    logic [FUEC_K+2*FUEC_R-1:0] st1_q;

    always_comb begin
      part_lo = '0;
      part_hi = '0;
      for (int j = 0; j < FUEC_R; j++) begin
        part_lo[j] = ^(s_data[15:0]  & FUEC_H_DATA[j][15:0]);
        part_hi[j] = ^(s_data[31:16] & FUEC_H_DATA[j][31:16]);
      end
    end

    fuec_pipe_stage #(.W(FUEC_K + 2*FUEC_R)) u_st1 (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (in_ready),
      .s_data  ({s_data, part_hi, part_lo}),
      .m_valid (st1_v),
      .m_ready (st2_ready),
      .m_data  (st1_q)
    );

    fuec_pipe_stage #(.W(FUEC_N)) u_st2 (
      .clk     (clk),
      .rst     (rst),
      .s_valid (st1_v),
      .s_ready (st2_ready),
      .s_data  ({st1_q[63:32], st1_q[31:16] ^ st1_q[15:0]}),
      .m_valid (code_v),
      .m_ready (m_ready),
      .m_data  (code_q)
    );
  end

  // Held low through reset so nothing is accepted into a pipe that is being flushed.
  assign s_ready = !rst && in_ready;
  assign m_valid = code_v;

  inj_state_t  state_q, state_d;
  logic [47:0] mask_q, mask_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    if (inj_clr) begin
      state_d = IDLE;
      mask_d  = '0;
    end else if (inj_load) begin
      state_d = inj_sticky ? STICKY : ARMED;
      mask_d  = inj_mask;
    end else if (state_q == ARMED && code_v && m_ready) begin
      state_d = IDLE;
    end
  end

  assign inj_active = (state_q != IDLE);
  assign m_code     = code_q ^ (inj_active ? mask_q : 48'h0);

  always_ff @(posedge clk) begin
    if (rst)                      word_cnt <= '0;
    else if (s_valid && s_ready)  word_cnt <= word_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fuec_encoder_48_32_stream.sv
// Directed bench for the FUEC(48,32) stream encoder, with a behavioural decoder on m_code.
module tb_fuec_encoder_48_32_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [47:0] m_code;
  logic        inj_load = 1'b0;
  logic [47:0] inj_mask = '0;
  logic        inj_sticky = 1'b0;
  logic        inj_clr = 1'b0;
  logic        inj_active;
  logic [3:0]  word_cnt;

  logic        en1 = 1'b0;
  logic        s_valid1;
  logic        s_ready1;
  logic        m_valid1;
  logic [47:0] m_code1;
  logic        inj_active1;
  logic [15:0] word_cnt1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [47:0] out_q[$];
  logic [47:0] q1[$];
  logic [47:0] exp2 [3] = '{48'hDEADBEEF_E8F3, 48'hFFFFFFFF_0000, 48'h00000001_0003};

  always #5 clk = ~clk;
  assign s_valid1 = s_valid && en1;

  fuec_encoder_48_32_stream #(.PIPE_STAGES(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_code(m_code),
    .inj_load(inj_load), .inj_mask(inj_mask), .inj_sticky(inj_sticky), .inj_clr(inj_clr),
    .inj_active(inj_active), .word_cnt(word_cnt)
  );

  fuec_encoder_48_32_stream #(.PIPE_STAGES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data),
    .m_valid(m_valid1), .m_ready(1'b1), .m_code(m_code1),
    .inj_load(1'b0), .inj_mask(48'h0), .inj_sticky(1'b0), .inj_clr(1'b0),
    .inj_active(inj_active1), .word_cnt(word_cnt1)
  );

  always @(negedge clk) begin
    #1;
    if (m_valid && m_ready) out_q.push_back(m_code);
    if (m_valid1) q1.push_back(m_code1);
  end

  function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [15:0] chk_of(input logic [31:0] d);
    return d[15:0] ^ rotl(d[15:0], 1) ^ d[31:16] ^ rotl(d[31:16], 3);
  endfunction

  function automatic logic [47:0] enc(input logic [31:0] d);
    return {d, chk_of(d)};
  endfunction

  function automatic logic [15:0] col(input int i);
    if (i < 16) return (16'h1 << i) | (16'h1 << ((i + 1) % 16));
    return (16'h1 << (i - 16)) | (16'h1 << ((i - 13) % 16));
  endfunction

  // 0 = no error, 1 = corrected, 2 = uncorrectable
  function automatic int dec_class(input logic [47:0] c, output logic [47:0] fix);
    logic [15:0] syn;
    syn = chk_of(c[47:16]) ^ c[15:0];
    fix = c;
    if (syn == 16'h0) return 0;
    for (int j = 0; j < 16; j++)
      if (syn == (16'h1 << j)) begin fix[j] = ~fix[j]; return 1; end
    for (int i = 0; i < 32; i++)
      if (syn == col(i)) begin fix[16+i] = ~fix[16+i]; return 1; end
    return 2;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [31:0] d);
    int k = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (!s_ready && k < 50) begin @(negedge clk); #1; k++; end
    check("send_accept", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (out_q.size() < n && k < 100) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    check("drain_count", 64'(out_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_q.delete();
    q1.delete();
  endtask

  task automatic inj_pulse(input logic [47:0] mask, input logic sticky);
    inj_load = 1'b1; inj_mask = mask; inj_sticky = sticky;
    @(negedge clk);
    inj_load = 1'b0;
  endtask

  initial begin
    logic [47:0] fix;
    logic [47:0] held;
    int          cls;

    // 1: reset values, then a zero word through the two-stage pipe
    repeat (2) @(negedge clk);
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_code", 64'(m_code), 64'd0);
    check("rst_inj_active", 64'(inj_active), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    send(32'h0);
    #1;
    check("lat_not_yet", 64'(m_valid), 64'd0);
    @(negedge clk); #1;
    check("lat_valid", 64'(m_valid), 64'd1);
    check("zero_code", 64'(m_code), 64'd0);
    cls = dec_class(m_code, fix);
    check("zero_no_error", 64'(cls), 64'd0);

    // 2: three words back-to-back, both pipe depths
    do_reset();
    en1 = 1'b1;
    send(32'hDEADBEEF);
    send(32'hFFFFFFFF);
    send(32'h00000001);
    en1 = 1'b0;
    wait_out(3);
    check("q1_count", 64'(q1.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stream_code%0d", i), 64'(out_q[i]), 64'(exp2[i]));
      check($sformatf("stream_p1_code%0d", i), 64'(q1[i]), 64'(exp2[i]));
      cls = dec_class(out_q[i], fix);
      check($sformatf("stream_syn%0d", i), 64'(cls), 64'd0);
    end
    check("stream_word_cnt", 64'(word_cnt), 64'd3);
    check("stream_p1_word_cnt", 64'(word_cnt1), 64'd3);

    // 3: backpressure with four words offered
    out_q.delete();
    m_ready = 1'b0;
    send(32'h1111_2222);
    send(32'h3333_4444);
    s_valid = 1'b1; s_data = 32'h5555_6666;
    #1;
    check("bp_s_ready_low", 64'(s_ready), 64'd0);
    check("bp_m_valid", 64'(m_valid), 64'd1);
    held = m_code;
    check("bp_head_code", 64'(held), 64'(enc(32'h1111_2222)));
    repeat (3) begin
      @(negedge clk); #1;
      check("bp_stable", 64'(m_code), 64'(held));
      check("bp_hold_ready", 64'(s_ready), 64'd0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    send(32'h5555_6666);
    send(32'h7777_8888);
    wait_out(4);
    check("bp_o0", 64'(out_q[0]), 64'(enc(32'h1111_2222)));
    check("bp_o1", 64'(out_q[1]), 64'(enc(32'h3333_4444)));
    check("bp_o2", 64'(out_q[2]), 64'(enc(32'h5555_6666)));
    check("bp_o3", 64'(out_q[3]), 64'(enc(32'h7777_8888)));

    // 4: one-shot single-bit injection
    out_q.delete();
    inj_pulse(48'h1 << 5, 1'b0);
    #1;
    check("arm_active", 64'(inj_active), 64'd1);
    @(negedge clk);
    send(32'hDEADBEEF);
    send(32'hDEADBEEF);
    wait_out(2);
    check("oneshot_code", 64'(out_q[0]), 64'h0000DEADBEEF_E8D3);
    cls = dec_class(out_q[0], fix);
    check("oneshot_corrected", 64'(cls), 64'd1);
    check("oneshot_fix_data", 64'(fix[47:16]), 64'hDEADBEEF);
    cls = dec_class(out_q[1], fix);
    check("oneshot_second_clean", 64'(cls), 64'd0);
    check("oneshot_inactive", 64'(inj_active), 64'd0);

    // 5: sticky multi-bit mask, then clear
    out_q.delete();
    inj_pulse(48'hF0F0F0F0F0F0, 1'b1);
    send(32'h0);
    send(32'hCAFE_F00D);
    send(32'h8000_0001);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      cls = dec_class(out_q[i], fix);
      check($sformatf("sticky_uncorr%0d", i), 64'(cls), 64'd2);
    end
    check("sticky_still_active", 64'(inj_active), 64'd1);
    inj_clr = 1'b1;
    @(negedge clk);
    inj_clr = 1'b0;
    #1;
    check("clr_inactive", 64'(inj_active), 64'd0);
    out_q.delete();
    send(32'h1234_5678);
    wait_out(1);
    check("clr_clean_code", 64'(out_q[0]), 64'(enc(32'h1234_5678)));

    // 6: counter wrap, then reset with words in flight
    do_reset();
    for (int i = 0; i < 17; i++) send(32'(i) * 32'h0101_0101);
    wait_out(17);
    check("cnt_wrap", 64'(word_cnt), 64'd1);
    out_q.delete();
    inj_pulse(48'h3, 1'b1);
    m_ready = 1'b0;
    send(32'hAAAA_5555);
    send(32'h5555_AAAA);
    #1;
    check("inflight_valid", 64'(m_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_inj_active", 64'(inj_active), 64'd0);
    check("midrst_word_cnt", 64'(word_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_nothing_emitted", 64'(out_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
